// File: rtl/snake_pkg.sv
// Shared command-word definitions for the snake core and its command executor.
package snake_pkg;
  localparam int CMD_WIDTH = 32;

  localparam logic [3:0] OP_DRAW = 4'h0;
  localparam logic [3:0] OP_FILL = 4'h1;

  // Opcode and field LSB positions inside the 32-bit command word
  localparam int OP_LSB      = 28;
  localparam int DRAW_X_LSB  = 23;
  localparam int DRAW_Y_LSB  = 18;
  localparam int DRAW_C_LSB  = 10;
  localparam int FILL_X0_LSB = 23;
  localparam int FILL_Y0_LSB = 18;
  localparam int FILL_X1_LSB = 13;
  localparam int FILL_Y1_LSB = 8;
  localparam int FILL_C_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_FILL
  } exec_state_t;
endpackage

// File: rtl/snake_cmd_fifo.sv
// Small synchronous command FIFO; registered storage, no fall-through.
// A push while full is accepted only when a pop happens in the same cycle.
module snake_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Storage write; head is read combinationally before the pop edge
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer update; extra MSB distinguishes full from empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/snake_cmd_exec.sv
// Draw-command executor: buffers the snake core's command stream and turns
// each DRAW/FILL into single-cycle tile-RAM writes. Sole writer of that RAM.
module snake_cmd_exec
  import snake_pkg::*;
#(
  parameter int                        H_LOGIC_WIDTH  = 5,
  parameter int                        V_LOGIC_WIDTH  = 5,
  parameter logic [H_LOGIC_WIDTH-1:0]  H_LOGIC_MAX    = 5'd31,
  parameter logic [V_LOGIC_WIDTH-1:0]  V_LOGIC_MAX    = 5'd23,
  parameter int                        COLOR_ID_WIDTH = 8,
  parameter int                        FIFO_DEPTH     = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CMD_WIDTH-1:0]                   cmd,
  input  logic                                   cmd_vld,
  output logic                                   wr_en,
  output logic [V_LOGIC_WIDTH+H_LOGIC_WIDTH-1:0] wr_addr,
  output logic [COLOR_ID_WIDTH-1:0]              wr_data,
  output logic                                   busy,
  output logic                                   ovf
);
  localparam int HW = H_LOGIC_WIDTH;
  localparam int VW = V_LOGIC_WIDTH;
  localparam int CW = COLOR_ID_WIDTH;
  localparam int NW = $clog2(FIFO_DEPTH) + 1;

  exec_state_t          state;
  logic [CMD_WIDTH-1:0] head;
  logic                 full, empty, push, pop;
  logic [NW-1:0]        count, cnt_next;

  // Fill walk registers: current cell, row restart x, clipped corner, colour
  logic [HW-1:0] cur_x, x0_r, x1c_r, nx;
  logic [VW-1:0] cur_y, y1c_r, ny;
  logic [CW-1:0] col_r;

  // Head-of-FIFO decode
  logic [3:0]    op;
  logic [HW-1:0] d_x, f_x0, f_x1, f_x1c;
  logic [VW-1:0] d_y, f_y0, f_y1, f_y1c;
  logic [CW-1:0] d_c, f_c;
  logic          fill_ok, x_last, y_last, idle_next;

  assign pop  = (state == ST_IDLE) && !empty;
  assign push = cmd_vld && (!full || pop);

  snake_cmd_fifo #(.WIDTH(CMD_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (cmd),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign op    = head[OP_LSB +: 4];
  assign d_x   = head[DRAW_X_LSB +: HW];
  assign d_y   = head[DRAW_Y_LSB +: VW];
  assign d_c   = head[DRAW_C_LSB +: CW];
  assign f_x0  = head[FILL_X0_LSB +: HW];
  assign f_y0  = head[FILL_Y0_LSB +: VW];
  assign f_x1  = head[FILL_X1_LSB +: HW];
  assign f_y1  = head[FILL_Y1_LSB +: VW];
  assign f_c   = head[FILL_C_LSB +: CW];
  assign f_x1c = (f_x1 > H_LOGIC_MAX) ? H_LOGIC_MAX : f_x1;
  assign f_y1c = (f_y1 > V_LOGIC_MAX) ? V_LOGIC_MAX : f_y1;
  // x0<=x1' already implies x0<=x1 since x1'<=x1; covers both reject cases
  assign fill_ok = (f_x0 <= f_x1c) && (f_y0 <= f_y1c);

  // Compare against the clipped corner before incrementing, so no wrap
  assign x_last = (cur_x == x1c_r);
  assign y_last = (cur_y == y1c_r);
  assign nx     = cur_x + 1'b1;
  assign ny     = cur_y + 1'b1;

  // Next-cycle IDLE prediction and FIFO occupancy, used for registered busy
  always_comb begin
    idle_next = 1'b1;
    case (state)
      ST_IDLE: idle_next = !(pop && ((op == OP_DRAW) || ((op == OP_FILL) && fill_ok)));
      ST_DRAW: idle_next = 1'b1;
      ST_FILL: idle_next = x_last && y_last;
      default: idle_next = 1'b1;
    endcase
    cnt_next = count + NW'(push) - NW'(pop);
  end

  // Command FSM; the write for a cell is registered on the edge entering
  // the cycle that shows it, so the pop cycle is the only overhead
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      cur_x   <= '0;
      cur_y   <= '0;
      x0_r    <= '0;
      x1c_r   <= '0;
      y1c_r   <= '0;
      col_r   <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            if (op == OP_DRAW) begin
              state <= ST_DRAW;
              if ((d_x <= H_LOGIC_MAX) && (d_y <= V_LOGIC_MAX)) begin
                wr_en   <= 1'b1;
                wr_addr <= {d_y, d_x};
                wr_data <= d_c;
              end
            end else if ((op == OP_FILL) && fill_ok) begin
              state   <= ST_FILL;
              wr_en   <= 1'b1;
              wr_addr <= {f_y0, f_x0};
              wr_data <= f_c;
              cur_x   <= f_x0;
              cur_y   <= f_y0;
              x0_r    <= f_x0;
              x1c_r   <= f_x1c;
              y1c_r   <= f_y1c;
              col_r   <= f_c;
            end
          end
        end
        ST_DRAW: state <= ST_IDLE;
        ST_FILL: begin
          if (x_last && y_last) begin
            state <= ST_IDLE;
          end else begin
            wr_en   <= 1'b1;
            wr_data <= col_r;
            if (x_last) begin
              cur_x   <= x0_r;
              cur_y   <= ny;
              wr_addr <= {ny, x0_r};
            end else begin
              cur_x   <= nx;
              wr_addr <= {cur_y, nx};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // busy tracks pending work one cycle ahead; ovf is sticky on any drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      busy <= !idle_next || (cnt_next != '0);
      ovf  <= ovf | (cmd_vld & ~push);
    end
  end
endmodule

// File: tb/tb_snake_cmd_exec.sv
// Directed bench for snake_cmd_exec: writes are logged at negedge with their
// cycle number and compared against hand-computed expectations.
module tb_snake_cmd_exec;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_vld = 1'b0;
  logic [31:0] cmd = '0;
  logic        wr_en, busy, ovf;
  logic [9:0]  wr_addr;
  logic [7:0]  wr_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int q_addr[$];
  int q_data[$];
  int q_cyc[$];

  snake_cmd_exec dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (cmd),
    .cmd_vld (cmd_vld),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && wr_en) begin
      q_addr.push_back(int'(wr_addr));
      q_data.push_back(int'(wr_data));
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_draw(input int x, input int y, input int c);
    return {4'h0, 5'(x), 5'(y), 8'(c), 10'b0};
  endfunction

  function automatic logic [31:0] mk_fill(input int x0, input int y0, input int x1, input int y1, input int c);
    return {4'h1, 5'(x0), 5'(y0), 5'(x1), 5'(y1), 8'(c)};
  endfunction

  // One cycle of input; called just after a posedge, returns just after the next
  task automatic step(input logic v, input logic [31:0] c);
    cmd_vld = v;
    cmd     = c;
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, bad, lim;

    // Reset state
    #2;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(ovf), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) step(1'b0, '0);

    // Single DRAW: latency 2, address {y,x}
    clear_log();
    n = cyc;
    step(1'b1, mk_draw(3, 7, 8'h0f));
    @(negedge clk);
    chk("draw_busy_n1", int'(busy), 1);
    chk("draw_no_wr_n1", int'(wr_en), 0);
    lim = 0;
    while (busy && lim < 20) begin
      @(negedge clk);
      lim++;
    end
    chk("draw_busy_drop_cyc", cyc, n + 3);
    @(posedge clk);
    #1;
    chk("draw_count", q_addr.size(), 1);
    if (q_addr.size() >= 1) begin
      chk("draw_cyc", q_cyc[0], n + 2);
      chk("draw_addr", q_addr[0], 227);
      chk("draw_data", q_data[0], 8'h0f);
    end

    // Full-screen FILL with a DRAW pushed while it runs
    clear_log();
    n = cyc;
    step(1'b1, mk_fill(0, 0, 31, 23, 8'hff));
    repeat (5) step(1'b0, '0);
    step(1'b1, mk_draw(1, 1, 8'h11));
    wait_idle(2000);
    chk("fill_count", q_addr.size(), 769);
    bad = 0;
    for (int i = 0; i < 768 && i < q_addr.size(); i++)
      if (q_addr[i] != i || q_data[i] != 8'hff || q_cyc[i] != n + 2 + i) bad++;
    chk("fill_seq_bad", bad, 0);
    if (q_addr.size() == 769) begin
      chk("fill_draw_addr", q_addr[768], 33);
      chk("fill_draw_data", q_data[768], 8'h11);
      chk("fill_draw_gap", q_cyc[768] - q_cyc[767], 2);
    end
    chk("fill_ovf", int'(ovf), 0);

    // Clipping and rejected commands, marker DRAW at the end
    clear_log();
    n = cyc;
    step(1'b1, mk_fill(30, 22, 31, 31, 8'h5a));
    step(1'b1, mk_draw(0, 24, 8'h77));
    step(1'b1, mk_fill(5, 0, 4, 3, 8'h66));
    step(1'b1, {4'h7, 28'h0abcdef});
    step(1'b1, mk_draw(2, 0, 8'h33));
    wait_idle(100);
    chk("clip_count", q_addr.size(), 5);
    if (q_addr.size() == 5) begin
      chk("clip_a0", q_addr[0], 734);
      chk("clip_a1", q_addr[1], 735);
      chk("clip_a2", q_addr[2], 766);
      chk("clip_a3", q_addr[3], 767);
      chk("clip_d3", q_data[3], 8'h5a);
      chk("clip_c0", q_cyc[0], n + 2);
      chk("marker_addr", q_addr[4], 2);
      chk("marker_data", q_data[4], 8'h33);
      chk("marker_cyc", q_cyc[4], n + 11);
    end

    // Overflow: 5 DRAWs behind a full-screen FILL, the 5th is dropped
    clear_log();
    step(1'b1, mk_fill(0, 0, 31, 23, 8'h01));
    for (int k = 1; k <= 4; k++) step(1'b1, mk_draw(k, 0, 8'ha0 + k));
    @(negedge clk);
    chk("ovf_before_5th", int'(ovf), 0);
    @(posedge clk);
    #1;
    step(1'b1, mk_draw(5, 0, 8'ha5));
    @(negedge clk);
    chk("ovf_after_5th", int'(ovf), 1);
    wait_idle(2000);
    chk("ovf_count", q_addr.size(), 772);
    if (q_addr.size() == 772) begin
      bad = 0;
      for (int k = 1; k <= 4; k++)
        if (q_addr[767 + k] != k || q_data[767 + k] != 8'ha0 + k) bad++;
      chk("ovf_draws_bad", bad, 0);
    end
    repeat (10) step(1'b0, '0);
    chk("ovf_sticky", int'(ovf), 1);

    // Asynchronous reset in the middle of a FILL
    step(1'b1, mk_fill(0, 0, 31, 23, 8'h42));
    repeat (50) step(1'b0, '0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_wr_en", int'(wr_en), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    chk("mid_rst_addr", int'(wr_addr), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_log();
    repeat (20) step(1'b0, '0);
    chk("post_rst_writes", q_addr.size(), 0);
    chk("post_rst_busy", int'(busy), 0);

    // FIFO full with a push on the IDLE pop cycle: accepted, no overflow
    clear_log();
    n = cyc;
    step(1'b1, mk_fill(0, 0, 3, 0, 8'hc0));
    for (int k = 1; k <= 4; k++) step(1'b1, mk_draw(7 + k, 0, 8'hb0 + k));
    step(1'b0, '0);
    step(1'b1, mk_draw(12, 0, 8'hb5));
    wait_idle(100);
    chk("fullpop_ovf", int'(ovf), 0);
    chk("fullpop_count", q_addr.size(), 9);
    if (q_addr.size() == 9) begin
      bad = 0;
      for (int i = 0; i < 4; i++)
        if (q_addr[i] != i || q_data[i] != 8'hc0) bad++;
      for (int k = 1; k <= 5; k++)
        if (q_addr[3 + k] != 7 + k || q_data[3 + k] != 8'hb0 + k) bad++;
      chk("fullpop_order_bad", bad, 0);
      chk("fullpop_last_cyc", q_cyc[8], n + 15);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
